pwm_timer_mc: RTL and testbench
===============================

PWM_TIMER_MC -- requirements
Module: pwm_timer_mc

Interface
REQ-001 Parameter CHANNELS, default 4, number of PWM/compare channels (1..16).
REQ-002 Parameter CNT_W, default 16, counter/top/compare width.
REQ-003 Parameter PRE_W, default 8, prescaler width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 go  input  1  run enable; 0 = freeze prescaler and counter.
REQ-007 relatch  input  1  request to load shadow inputs into active registers.
REQ-008 mode  input  1  shadow mode: 0 edge-aligned (up-count), 1 center-aligned (up/down).
REQ-009 prescaler_cnt  input  PRE_W  shadow prescaler P; tick every P+1 clocks.
REQ-010 top_cnt  input  CNT_W  shadow top T.
REQ-011 cmp_cnt  input  CHANNELS*CNT_W  shadow compares; channel i in bits [i*CNT_W +: CNT_W].
REQ-012 counter  output  CNT_W  current counter value, registered.
REQ-013 top_match  output  1  one-cycle pulse, counter at top.
REQ-014 cmp_match  output  CHANNELS  one-cycle pulse per channel, counter equals compare.
REQ-015 pwm  output  CHANNELS  registered PWM outputs, active-high.
REQ-016 latched  output  1  one-cycle pulse when shadow values become active.

Function
REQ-017 The block SHALL keep active registers P_a, T_a, mode_a, cmp_a[i]; only these drive counting and comparison.
REQ-018 Prescaler SHALL count 0..P_a while go=1 and assert an internal tick in the cycle it equals P_a, then return to 0.
REQ-019 Edge mode: on tick, counter SHALL increment, wrapping T_a -> 0; period (P_a+1)*(T_a+1) clocks.
REQ-020 Center mode: on tick, counter SHALL count up to T_a, reverse, count down to 0, reverse; period 2*T_a*(P_a+1) clocks; T_a=0 holds counter at 0.
REQ-021 Direction flag SHALL be up after reset, on any relatch apply, and on entering edge mode.
REQ-022 pwm[i] SHALL equal (counter < cmp_a[i]) in every cycle; cmp_a[i]=0 gives constant 0; cmp_a[i]>T_a gives constant 1.
REQ-023 top_match SHALL pulse in the cycle of a tick where counter==T_a.
REQ-024 cmp_match[i] SHALL pulse in the cycle of a tick where counter==cmp_a[i].
REQ-025 A relatch=1 sample SHALL set a pending flag; further relatch while pending has no extra effect.
REQ-026 Pending SHALL apply at the period boundary: edge, tick with counter==T_a; center, tick with counter==0 while counting down, or any tick when T_a=0.
REQ-027 Apply SHALL copy all shadow inputs to active registers, set counter 0, prescaler 0, direction up, clear pending, pulse latched, all in one cycle.
REQ-028 relatch asserted in the same cycle as a boundary tick SHALL apply at that boundary.
REQ-029 When go=0, pending (or relatch) SHALL apply on the next clock; counter, prescaler and pwm otherwise hold; top_match/cmp_match SHALL be 0.
REQ-030 Counter arithmetic SHALL be CNT_W bits, never exceeding T_a in steady state.

Reset
REQ-031 rst SHALL asynchronously clear counter, prescaler, all active registers, pending, direction (up), pwm, top_match, cmp_match, latched to 0.
REQ-032 After release with go=1, counter SHALL stay 0 with top_match pulsing every clock until the first relatch applies.
REQ-033 rst asserted mid-period SHALL abort the period; no pending relatch survives.

Verification
REQ-034 CHANNELS=4, P=3, T=255, cmp={0,64,128,300}, mode=0, go=1, relatch 1 clock -> period 1024 clocks; pwm high 0/256/512/1024 clocks; top_match every 1024.
REQ-035 P=0, T=4, mode=1, cmp[0]=2 -> counter 0,1,2,3,4,3,2,1 repeating; pwm[0] high 3 of 8 clocks; top_match once per 8.
REQ-036 Edge run with cmp[0]=128; at counter=100 set cmp[0]=32 and pulse relatch -> duty unchanged until wrap; latched pulses on wrap tick; next period duty 32*(P+1).
REQ-037 go=0 at counter=77 for 50 clocks -> counter holds 77, no match pulses; relatch while stopped -> latched next clock, counter 0.
REQ-038 rst pulse mid-period (between edges) -> all outputs 0 immediately; after release, counter 0 and top_match every clock until relatch.

Source files
------------

// File: rtl/pwm_timer_mc.sv
// Multi-channel PWM timer with a prescaler, edge/center-aligned counting and
// shadow registers that take effect only at a period boundary (or right away while stopped).
module pwm_timer_mc #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int PRE_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go,
  input  logic                      relatch,
  input  logic                      mode,
  input  logic [PRE_W-1:0]          prescaler_cnt,
  input  logic [CNT_W-1:0]          top_cnt,
  input  logic [CHANNELS*CNT_W-1:0] cmp_cnt,
  output logic [CNT_W-1:0]          counter,
  output logic                      top_match,
  output logic [CHANNELS-1:0]       cmp_match,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      latched
);

  logic [PRE_W-1:0]          r_pre, r_p_a;
  logic [CNT_W-1:0]          r_cnt, r_t_a;
  logic [CHANNELS*CNT_W-1:0] r_cmp_a;
  logic                      r_mode_a, r_dir_down, r_pending, r_latched;
  logic [CHANNELS-1:0]       r_pwm;

  logic                      w_tick, w_at_top, w_boundary, w_req, w_apply;
  logic [PRE_W-1:0]          w_pre_nxt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      w_dir_nxt;
  logic [CHANNELS*CNT_W-1:0] w_cmp_nxt;
  logic [CHANNELS-1:0]       w_pwm_nxt;
  logic [CHANNELS-1:0]       w_cmp_hit;

  assign w_tick   = go & ~rst & (r_pre == r_p_a);
  assign w_at_top = (r_cnt == r_t_a);
  // Center mode closes its period on the down-count reaching zero; T=0 makes every tick a boundary.
  assign w_boundary = w_tick & (r_mode_a ? ((r_t_a == '0) | ((r_cnt == '0) & r_dir_down))
                                         : w_at_top);
  assign w_req   = r_pending | relatch;
  assign w_apply = w_req & (~go | w_boundary);

  always_comb begin
    w_pre_nxt = r_pre;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir_down;
    w_cmp_nxt = r_cmp_a;
    if (w_apply) begin
      w_pre_nxt = '0;
      w_cnt_nxt = '0;
      w_dir_nxt = 1'b0;
      w_cmp_nxt = cmp_cnt;
    end else if (go) begin
      w_pre_nxt = w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) begin
        if (!r_mode_a) begin
          w_cnt_nxt = w_at_top ? '0 : r_cnt + CNT_W'(1);
          w_dir_nxt = 1'b0;
        end else if (r_t_a == '0) begin
          w_cnt_nxt = '0;
          w_dir_nxt = 1'b0;
        end else if (!r_dir_down) begin
          w_cnt_nxt = w_at_top ? r_cnt - CNT_W'(1) : r_cnt + CNT_W'(1);
          w_dir_nxt = w_at_top;
        end else begin
          w_cnt_nxt = (r_cnt == '0) ? CNT_W'(1) : r_cnt - CNT_W'(1);
          w_dir_nxt = (r_cnt != '0);
        end
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else begin
      w_pre_nxt = r_pre;
    end
  end

  // PWM is registered from the next-cycle counter/compare so it always matches the visible counter.
  always_comb begin
    w_pwm_nxt = '0;
    w_cmp_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_pwm_nxt[i] = (w_cnt_nxt < w_cmp_nxt[i*CNT_W +: CNT_W]);
      w_cmp_hit[i] = w_tick & (r_cnt == r_cmp_a[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre      <= '0;
      r_p_a      <= '0;
      r_cnt      <= '0;
      r_t_a      <= '0;
      r_cmp_a    <= '0;
      r_mode_a   <= 1'b0;
      r_dir_down <= 1'b0;
      r_pending  <= 1'b0;
      r_latched  <= 1'b0;
      r_pwm      <= '0;
    end else begin
      r_pre      <= w_pre_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dir_down <= w_dir_nxt;
      r_cmp_a    <= w_cmp_nxt;
      r_pwm      <= w_pwm_nxt;
      r_pending  <= w_apply ? 1'b0 : w_req;
      r_latched  <= w_apply;
      if (w_apply) begin
        r_p_a    <= prescaler_cnt;
        r_t_a    <= top_cnt;
        r_mode_a <= mode;
      end
    end
  end

  assign counter   = r_cnt;
  assign pwm       = r_pwm;
  assign latched   = r_latched;
  assign top_match = w_tick & w_at_top;
  assign cmp_match = w_cmp_hit;

endmodule

// File: tb/tb_pwm_timer_mc.sv
// Directed bench for pwm_timer_mc: expectations queued at stimulus time, checked on DUT output.
module tb_pwm_timer_mc;
  logic        clk = 1'b0;
  logic        rst, go, relatch, mode;
  logic [7:0]  prescaler_cnt;
  logic [15:0] top_cnt;
  logic [63:0] cmp_cnt;
  logic [15:0] counter;
  logic        top_match, latched;
  logic [3:0]  cmp_match, pwm;

  pwm_timer_mc #(.CHANNELS(4), .CNT_W(16), .PRE_W(8)) dut (
    .clk(clk), .rst(rst), .go(go), .relatch(relatch), .mode(mode),
    .prescaler_cnt(prescaler_cnt), .top_cnt(top_cnt), .cmp_cnt(cmp_cnt),
    .counter(counter), .top_match(top_match), .cmp_match(cmp_match),
    .pwm(pwm), .latched(latched)
  );

  always #5 clk = ~clk;

  int exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_pwm_hi[4];
  int m_cmp[4];
  int m_top, m_lat, m_cnt_ne, m_pwm_ne, m_cnt_max;

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input int obs);
    int e;
    if (exp_q.size() == 0) e = -1;
    else e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  task automatic measure(input int n, input logic [15:0] hold_cnt, input logic [3:0] hold_pwm);
    for (int c = 0; c < 4; c++) begin m_pwm_hi[c] = 0; m_cmp[c] = 0; end
    m_top = 0; m_lat = 0; m_cnt_ne = 0; m_pwm_ne = 0; m_cnt_max = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        m_pwm_hi[c] += int'(pwm[c]);
        m_cmp[c]    += int'(cmp_match[c]);
      end
      m_top    += int'(top_match);
      m_lat    += int'(latched);
      m_cnt_ne += int'(counter != hold_cnt);
      m_pwm_ne += int'(pwm != hold_pwm);
      if (int'(counter) > m_cnt_max) m_cnt_max = int'(counter);
    end
  endtask

  task automatic wait_cnt(input logic [15:0] v, output bit found);
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      if (counter == v) found = 1'b1;
    end
  endtask

  int seq[16] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0};

  initial begin
    bit        found;
    int        pwm2_at120, prev_cnt, cnt_at_lat;
    rst = 1'b1; go = 1'b1; relatch = 1'b0; mode = 1'b0;
    prescaler_cnt = 8'd0; top_cnt = 16'd0; cmp_cnt = 64'd0;

    // Outputs while held in reset
    repeat (2) @(negedge clk);
    push(0); push(0); push(0); push(0); push(0);
    chk("rst_counter", int'(counter)); chk("rst_pwm", int'(pwm));
    chk("rst_top", int'(top_match)); chk("rst_cmp", int'(cmp_match));
    chk("rst_latched", int'(latched));

    // After release: counter stuck at 0, top_match every clock
    rst = 1'b0;
    push(0); push(5); push(0);
    measure(5, 16'd0, 4'd0);
    chk("post_rst_cnt", m_cnt_ne); chk("post_rst_top", m_top); chk("post_rst_lat", m_lat);

    // Edge mode P=3 T=255 cmp={0,64,128,300}
    prescaler_cnt = 8'd3; top_cnt = 16'd255; mode = 1'b0;
    cmp_cnt = {16'd300, 16'd128, 16'd64, 16'd0};
    @(posedge clk); #1 relatch = 1'b1;
    @(posedge clk); #1 relatch = 1'b0;
    @(negedge clk);
    push(1); push(0);
    chk("edge_latched", int'(latched)); chk("edge_cnt0", int'(counter));
    push(0); push(256); push(512); push(1024); push(1); push(1); push(1); push(1); push(0);
    push(0); push(255);
    measure(1024, 16'd0, 4'd0);
    chk("edge_pwm0", m_pwm_hi[0]); chk("edge_pwm1", m_pwm_hi[1]);
    chk("edge_pwm2", m_pwm_hi[2]); chk("edge_pwm3", m_pwm_hi[3]);
    chk("edge_top", m_top);
    chk("edge_cmp0", m_cmp[0]); chk("edge_cmp1", m_cmp[1]);
    chk("edge_cmp2", m_cmp[2]); chk("edge_cmp3", m_cmp[3]);
    chk("edge_lat", m_lat); chk("edge_cnt_max", m_cnt_max);

    // Mid-period relatch of cmp[2]: 128 -> 32 waits for the wrap
    push(1);
    wait_cnt(16'd100, found);
    chk("wait_100", int'(found));
    cmp_cnt[2*16 +: 16] = 16'd32;
    relatch = 1'b1;
    @(negedge clk); relatch = 1'b0;
    pwm2_at120 = -1; prev_cnt = -1; cnt_at_lat = -1;
    for (int k = 0; k < 2000; k++) begin
      if (latched) begin
        cnt_at_lat = int'(counter);
        break;
      end
      if (counter == 16'd120 && pwm2_at120 < 0) pwm2_at120 = int'(pwm[2]);
      prev_cnt = int'(counter);
      @(negedge clk);
    end
    push(1); push(0); push(255);
    chk("shadow_old_duty", pwm2_at120); chk("lat_cnt", cnt_at_lat); chk("lat_prev_cnt", prev_cnt);
    push(128); push(256); push(1);
    measure(1024, 16'd0, 4'd0);
    chk("new_pwm2", m_pwm_hi[2]); chk("new_pwm1", m_pwm_hi[1]); chk("new_top", m_top);

    // Stop at 77 for 50 clocks, then relatch while stopped
    push(1);
    wait_cnt(16'd77, found);
    chk("wait_77", int'(found));
    go = 1'b0;
    push(0); push(0); push(0); push(0); push(0);
    measure(50, 16'd77, 4'b1000);
    chk("stop_cnt_hold", m_cnt_ne); chk("stop_pwm_hold", m_pwm_ne);
    chk("stop_top", m_top); chk("stop_cmp", m_cmp[0] + m_cmp[1] + m_cmp[2] + m_cmp[3]);
    chk("stop_lat", m_lat);
    relatch = 1'b1;
    @(negedge clk); relatch = 1'b0;
    push(1); push(0); push(4'b1110);
    chk("stop_latched", int'(latched)); chk("stop_cnt0", int'(counter)); chk("stop_pwm", int'(pwm));

    // Center mode P=0 T=4 cmp[0]=2
    prescaler_cnt = 8'd0; top_cnt = 16'd4; mode = 1'b1;
    cmp_cnt[15:0] = 16'd2;
    relatch = 1'b1;
    @(negedge clk); relatch = 1'b0;
    push(1); push(0);
    chk("ctr_latched", int'(latched)); chk("ctr_cnt0", int'(counter));
    go = 1'b1;
    for (int k = 0; k < 16; k++) push(seq[k]);
    m_pwm_hi[0] = 0; m_top = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("ctr_seq", int'(counter));
      m_pwm_hi[0] += int'(pwm[0]);
      m_top       += int'(top_match);
    end
    push(6); push(2);
    chk("ctr_pwm0", m_pwm_hi[0]); chk("ctr_top", m_top);

    // Reset mid-period with a relatch pending
    repeat (2) @(negedge clk);
    relatch = 1'b1;
    @(posedge clk); #1 relatch = 1'b0;
    #2 rst = 1'b1;
    #1;
    push(0); push(0); push(0); push(0); push(0);
    chk("mid_rst_cnt", int'(counter)); chk("mid_rst_pwm", int'(pwm));
    chk("mid_rst_top", int'(top_match)); chk("mid_rst_cmp", int'(cmp_match));
    chk("mid_rst_lat", int'(latched));
    @(negedge clk); rst = 1'b0;
    push(0); push(8); push(0);
    measure(8, 16'd0, 4'd0);
    chk("rel_cnt", m_cnt_ne); chk("rel_top", m_top); chk("rel_no_pending", m_lat);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
